// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types and arithmetic helpers for the product accumulator
package accum_pkg;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  localparam int SAT_MAX_WIDTH = 64;

  function automatic int acc_width(input int data_width, input int num_taps);
    return data_width + $clog2(num_taps);
  endfunction

  // Clamp to the signed range of out_width bits; out_width must be below SAT_MAX_WIDTH.
  function automatic logic signed [SAT_MAX_WIDTH-1:0] saturate(
    input logic signed [SAT_MAX_WIDTH-1:0] value,
    input int                              out_width
  );
    logic signed [SAT_MAX_WIDTH-1:0] hi;
    logic signed [SAT_MAX_WIDTH-1:0] lo;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end
    if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// rtl/sat_shift.sv - arithmetic right shift (floor) followed by signed saturation
module sat_shift
  import accum_pkg::*;
#(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 10
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  logic signed [IN_WIDTH-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    dout    = OUT_WIDTH'(saturate(SAT_MAX_WIDTH'(shifted), OUT_WIDTH));
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums NUM_TAPS products, rescales, saturates and writes to the output FIFO
module product_accumulator
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 16,
  parameter int FRAC_BITS  = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] product_in,
  input  logic                         product_valid,
  output logic                         product_rd_en,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic signed [DATA_WIDTH-1:0] out_din
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, NUM_TAPS);
  localparam int CNT_WIDTH = $clog2(NUM_TAPS);
  localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(NUM_TAPS - 1);

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [CNT_WIDTH-1:0]   count_q, count_d;
  logic signed [DATA_WIDTH-1:0]  result_q, result_d;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [DATA_WIDTH-1:0]  scaled;

  // The final product is folded in combinationally so the result is ready on the last pop edge.
  assign sum = acc_q + ACC_WIDTH'(product_in);

  sat_shift #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .SHIFT     (FRAC_BITS)
  ) u_sat_shift (
    .din  (sum),
    .dout (scaled)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    count_d       = count_q;
    result_d      = result_q;
    product_rd_en = 1'b0;
    out_wr_en     = 1'b0;
    case (state_q)
      S_ACCUM: begin
        product_rd_en = product_valid;
        if (product_valid) begin
          if (count_q == LAST_TAP) begin
            result_d = scaled;
            acc_d    = '0;
            count_d  = '0;
            state_d  = S_WRITE;
          end else begin
            acc_d   = sum;
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          state_d = S_ACCUM;
        end
      end
    endcase
    if (!reset) begin
      product_rd_en = 1'b0;
      out_wr_en     = 1'b0;
    end
    out_din = reset ? result_q : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_ACCUM;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule
